// File: rtl/riscv_biu_pkg.sv
// Shared BIU definitions: burst-type encodings, beat-count helper and the arbiter state type.
package riscv_biu_pkg;

  localparam logic [2:0] SINGLE = 3'd0;
  localparam logic [2:0] INCR   = 3'd1;
  localparam logic [2:0] WRAP4  = 3'd2;
  localparam logic [2:0] INCR4  = 3'd3;
  localparam logic [2:0] WRAP8  = 3'd4;
  localparam logic [2:0] INCR8  = 3'd5;
  localparam logic [2:0] WRAP16 = 3'd6;
  localparam logic [2:0] INCR16 = 3'd7;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  function automatic logic [4:0] biu_type2beats(input logic [2:0] btype);
    logic [4:0] beats;
    case (btype)
      SINGLE, INCR:   beats = 5'd1;
      WRAP4, INCR4:   beats = 5'd4;
      WRAP8, INCR8:   beats = 5'd8;
      WRAP16, INCR16: beats = 5'd16;
      default:        beats = 5'd1;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/riscv_biu_arbiter.sv
// Two-master (fetch=0, data=1) to one-slave BIU arbiter; re-arbitrates only at burst
// boundaries with round-robin tie-break and lock hold.
module riscv_biu_arbiter
  import riscv_biu_pkg::*;
#(
  parameter int XLEN            = 64,
  parameter int PLEN            = 64,
  parameter int MAX_OUTSTANDING = 31
) (
  input  logic                       HCLK,
  input  logic                       HRESET,

  input  logic [1:0]                 m_biu_stb_i,
  input  logic [1:0][PLEN-1:0]       m_biu_adri_i,
  input  logic [1:0][2:0]            m_biu_size_i,
  input  logic [1:0][2:0]            m_biu_type_i,
  input  logic [1:0][2:0]            m_biu_prot_i,
  input  logic [1:0]                 m_biu_lock_i,
  input  logic [1:0]                 m_biu_we_i,
  input  logic [1:0][XLEN-1:0]       m_biu_d_i,
  output logic [1:0]                 m_biu_stb_ack_o,
  output logic [1:0]                 m_biu_d_ack_o,
  output logic [1:0]                 m_biu_ack_o,
  output logic [1:0]                 m_biu_err_o,
  output logic [1:0][XLEN-1:0]       m_biu_q_o,
  output logic [1:0][PLEN-1:0]       m_biu_adro_o,

  output logic                       biu_stb_o,
  output logic [PLEN-1:0]            biu_adri_o,
  output logic [2:0]                 biu_size_o,
  output logic [2:0]                 biu_type_o,
  output logic [2:0]                 biu_prot_o,
  output logic                       biu_lock_o,
  output logic                       biu_we_o,
  output logic [XLEN-1:0]            biu_d_o,
  input  logic                       biu_stb_ack_i,
  input  logic                       biu_d_ack_i,
  input  logic                       biu_ack_i,
  input  logic                       biu_err_i,
  input  logic [XLEN-1:0]            biu_q_i,
  input  logic [PLEN-1:0]            biu_adro_i
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = CW + 6;

  arb_state_t    state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [CW-1:0] pending_q, pending_d;
  logic [SW-1:0] pending_sum;
  logic [4:0]    beats;
  logic          in_grant;
  logic          release_grant;

  assign in_grant = (state_q == GRANT);

  // Request path: fields always follow the current owner; strobe/lock gated by state
  always_comb begin
    biu_adri_o = m_biu_adri_i[owner_q];
    biu_size_o = m_biu_size_i[owner_q];
    biu_type_o = m_biu_type_i[owner_q];
    biu_prot_o = m_biu_prot_i[owner_q];
    biu_we_o   = m_biu_we_i[owner_q];
    biu_d_o    = m_biu_d_i[owner_q];
    biu_lock_o = in_grant & m_biu_lock_i[owner_q];
    biu_stb_o  = in_grant & m_biu_stb_i[owner_q] & ~release_grant;
  end

  // Response path: handshakes to the owner only, data/address broadcast
  always_comb begin
    m_biu_stb_ack_o = 2'b00;
    m_biu_d_ack_o   = 2'b00;
    m_biu_ack_o     = 2'b00;
    m_biu_err_o     = 2'b00;
    if (in_grant) begin
      m_biu_stb_ack_o[owner_q] = biu_stb_ack_i;
      m_biu_d_ack_o[owner_q]   = biu_d_ack_i;
      m_biu_ack_o[owner_q]     = biu_ack_i;
      m_biu_err_o[owner_q]     = biu_err_i;
    end
    m_biu_q_o    = {biu_q_i, biu_q_i};
    m_biu_adro_o = {biu_adro_i, biu_adro_i};
  end

  always_comb begin
    beats       = biu_type2beats(biu_type_o);
    pending_sum = SW'(pending_q) + (biu_stb_ack_i ? SW'(beats) : '0);
    if (biu_ack_i && (pending_sum != '0)) begin
      pending_sum = pending_sum - SW'(1);
    end
    pending_d = biu_err_i ? '0 : pending_sum[CW-1:0];
  end

  // Release only on an idle boundary, and only if the owner is done or someone else waits
  always_comb begin
    release_grant = in_grant
                  && (pending_d == '0)
                  && !biu_stb_ack_i
                  && !m_biu_lock_i[owner_q]
                  && (!m_biu_stb_i[owner_q] || m_biu_stb_i[~owner_q]);
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (|m_biu_stb_i) begin
          state_d = GRANT;
          owner_d = (&m_biu_stb_i) ? ~last_q : m_biu_stb_i[1];
        end
      end
      GRANT: begin
        if (release_grant) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      pending_q <= pending_d;
    end
  end

  a_pending_overflow: assert property (@(posedge HCLK) disable iff (HRESET)
    (SW'(pending_q) + (biu_stb_ack_i ? SW'(beats) : '0)) <= SW'(MAX_OUTSTANDING));

  a_pending_underflow: assert property (@(posedge HCLK) disable iff (HRESET)
    !(biu_ack_i && !biu_stb_ack_i && (pending_q == '0)));

endmodule

// File: tb/tb_riscv_biu_arbiter.sv
// Directed bench for riscv_biu_arbiter: single transfers, tie-break, bursts, error, lock, reset.
module tb_riscv_biu_arbiter;
  import riscv_biu_pkg::*;

  localparam int XLEN = 64;
  localparam int PLEN = 64;

  logic                 HCLK;
  logic                 HRESET;
  logic [1:0]           stb, lock, we;
  logic [1:0][PLEN-1:0] adri;
  logic [1:0][2:0]      size, btype, prot;
  logic [1:0][XLEN-1:0] wd;
  logic [1:0]           m_stb_ack, m_d_ack, m_ack, m_err;
  logic [1:0][XLEN-1:0] m_q;
  logic [1:0][PLEN-1:0] m_adro;
  logic                 b_stb, b_lock, b_we;
  logic [PLEN-1:0]      b_adri;
  logic [2:0]           b_size, b_type, b_prot;
  logic [XLEN-1:0]      b_d;
  logic                 s_stb_ack, s_d_ack, s_ack, s_err;
  logic [XLEN-1:0]      s_q;
  logic [PLEN-1:0]      s_adro;

  int total = 0;
  int bad   = 0;

  riscv_biu_arbiter #(.XLEN(XLEN), .PLEN(PLEN), .MAX_OUTSTANDING(31)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .m_biu_stb_i(stb), .m_biu_adri_i(adri), .m_biu_size_i(size), .m_biu_type_i(btype),
    .m_biu_prot_i(prot), .m_biu_lock_i(lock), .m_biu_we_i(we), .m_biu_d_i(wd),
    .m_biu_stb_ack_o(m_stb_ack), .m_biu_d_ack_o(m_d_ack), .m_biu_ack_o(m_ack),
    .m_biu_err_o(m_err), .m_biu_q_o(m_q), .m_biu_adro_o(m_adro),
    .biu_stb_o(b_stb), .biu_adri_o(b_adri), .biu_size_o(b_size), .biu_type_o(b_type),
    .biu_prot_o(b_prot), .biu_lock_o(b_lock), .biu_we_o(b_we), .biu_d_o(b_d),
    .biu_stb_ack_i(s_stb_ack), .biu_d_ack_i(s_d_ack), .biu_ack_i(s_ack), .biu_err_i(s_err),
    .biu_q_i(s_q), .biu_adro_i(s_adro)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    HRESET = 1'b1;
    stb = '0; lock = '0; we = '0; adri = '0; size = '0; btype = '0; prot = '0; wd = '0;
    s_stb_ack = 0; s_d_ack = 0; s_ack = 0; s_err = 0; s_q = '0; s_adro = '0;
    cyc(); cyc();
    check_eq("rst_state", 64'(dut.state_q), 64'(IDLE));
    check_eq("rst_pending", 64'(dut.pending_q), 0);
    check_eq("rst_owner", 64'(dut.owner_q), 0);
    check_eq("rst_last", 64'(dut.last_q), 0);
    check_eq("rst_stb", 64'(b_stb), 0);
    check_eq("rst_ack", 64'(m_ack), 0);
    HRESET = 1'b0;

    // Master 1 single read, master 0 idle
    stb = 2'b10; adri[1] = 64'h1000; btype[1] = SINGLE;
    #1 check_eq("t1_idle_stb", 64'(b_stb), 0);
    cyc();
    check_eq("t1_state", 64'(dut.state_q), 64'(GRANT));
    check_eq("t1_stb", 64'(b_stb), 1);
    check_eq("t1_adr", b_adri, 64'h1000);
    s_stb_ack = 1;
    #1 check_eq("t1_stb_ack", 64'(m_stb_ack), 64'b10);
    cyc();
    stb = 2'b00; s_stb_ack = 0; s_ack = 1; s_q = 64'hABCD; s_adro = 64'h1000;
    #1 check_eq("t1_ack", 64'(m_ack), 64'b10);
    check_eq("t1_q0", m_q[0], 64'hABCD);
    check_eq("t1_q1", m_q[1], 64'hABCD);
    check_eq("t1_adro0", m_adro[0], 64'h1000);
    check_eq("t1_pending", 64'(dut.pending_q), 1);
    cyc();
    s_ack = 0;
    check_eq("t1_idle", 64'(dut.state_q), 64'(IDLE));
    check_eq("t1_last", 64'(dut.last_q), 1);

    // Simultaneous requests right after reset: master 1 first
    HRESET = 1'b1; cyc(); HRESET = 1'b0;
    stb = 2'b11; adri[0] = 64'h2000; adri[1] = 64'h3000; btype = '0;
    cyc();
    check_eq("t2_owner1", 64'(dut.owner_q), 1);
    check_eq("t2_adr1", b_adri, 64'h3000);
    s_stb_ack = 1;
    #1 check_eq("t2_stb_ack1", 64'(m_stb_ack), 64'b10);
    cyc();
    stb[1] = 0; s_stb_ack = 0; s_ack = 1;
    #1 check_eq("t2_ack1", 64'(m_ack), 64'b10);
    cyc();
    s_ack = 0;
    check_eq("t2_gap_idle", 64'(dut.state_q), 64'(IDLE));
    check_eq("t2_gap_stb", 64'(b_stb), 0);
    cyc();
    check_eq("t2_owner0", 64'(dut.owner_q), 0);
    check_eq("t2_adr0", b_adri, 64'h2000);
    s_stb_ack = 1;
    #1 check_eq("t2_stb_ack0", 64'(m_stb_ack), 64'b01);
    cyc();
    stb[0] = 0; s_stb_ack = 0; s_ack = 1;
    #1 check_eq("t2_ack0", 64'(m_ack), 64'b01);
    cyc();
    s_ack = 0;
    check_eq("t2_end_idle", 64'(dut.state_q), 64'(IDLE));

    // Master 0 INCR8 while master 1 waits
    stb = 2'b01; adri[0] = 64'h4000; btype[0] = INCR8;
    cyc();
    s_stb_ack = 1; stb[1] = 1; btype[1] = SINGLE;
    cyc();
    check_eq("t3_pend8", 64'(dut.pending_q), 8);
    stb[0] = 0; s_stb_ack = 0; s_ack = 1;
    for (int i = 0; i < 8; i++) begin
      #1 check_eq("t3_hold_owner", 64'(dut.owner_q), 0);
      cyc();
      check_eq("t3_pend", 64'(dut.pending_q), 64'(7 - i));
      if (i < 7) check_eq("t3_hold_state", 64'(dut.state_q), 64'(GRANT));
    end
    s_ack = 0;
    check_eq("t3_release", 64'(dut.state_q), 64'(IDLE));
    cyc();
    check_eq("t3_owner1", 64'(dut.owner_q), 1);
    check_eq("t3_adr1", b_adri, 64'h3000);
    s_stb_ack = 1;
    cyc();
    stb = 2'b00; s_stb_ack = 0; s_ack = 1;
    cyc();
    s_ack = 0;

    // WRAP4 aborted by slave error on the third beat
    stb = 2'b10; adri[1] = 64'h5000; btype[1] = WRAP4;
    cyc();
    s_stb_ack = 1;
    cyc();
    check_eq("t4_pend4", 64'(dut.pending_q), 4);
    stb = 2'b00; s_stb_ack = 0; s_ack = 1;
    cyc(); cyc();
    check_eq("t4_pend2", 64'(dut.pending_q), 2);
    s_ack = 0; s_err = 1;
    #1 check_eq("t4_err", 64'(m_err), 64'b10);
    cyc();
    s_err = 0;
    check_eq("t4_pend0", 64'(dut.pending_q), 0);
    check_eq("t4_idle", 64'(dut.state_q), 64'(IDLE));

    // Master 1 locked across two singles while master 0 requests
    stb = 2'b10; lock[1] = 1; adri[1] = 64'h6000; btype[1] = SINGLE;
    cyc();
    check_eq("t5_lock_o", 64'(b_lock), 1);
    s_stb_ack = 1; stb[0] = 1; adri[0] = 64'h7000; btype[0] = SINGLE;
    cyc();
    stb[1] = 0; s_stb_ack = 0; s_ack = 1;
    #1 check_eq("t5_ack1", 64'(m_ack), 64'b10);
    cyc();
    s_ack = 0;
    check_eq("t5_held_a", 64'(dut.state_q), 64'(GRANT));
    check_eq("t5_pend0", 64'(dut.pending_q), 0);
    stb[1] = 1; s_stb_ack = 1;
    #1 check_eq("t5_stb_ack1", 64'(m_stb_ack), 64'b10);
    cyc();
    stb[1] = 0; s_stb_ack = 0; s_ack = 1;
    cyc();
    s_ack = 0;
    cyc();
    check_eq("t5_held_b", 64'(dut.state_q), 64'(GRANT));
    check_eq("t5_owner_b", 64'(dut.owner_q), 1);
    lock[1] = 0;
    cyc();
    check_eq("t5_release", 64'(dut.state_q), 64'(IDLE));
    cyc();
    check_eq("t5_owner0", 64'(dut.owner_q), 0);
    check_eq("t5_adr0", b_adri, 64'h7000);
    s_stb_ack = 1;
    cyc();
    stb = 2'b00; s_stb_ack = 0; s_ack = 1;
    cyc();
    s_ack = 0;

    // Reset in the middle of an INCR16 with 9 beats pending
    stb = 2'b01; adri[0] = 64'h8000; btype[0] = INCR16;
    cyc();
    s_stb_ack = 1;
    cyc();
    check_eq("t6_pend16", 64'(dut.pending_q), 16);
    s_stb_ack = 0; s_ack = 1;
    for (int i = 0; i < 7; i++) cyc();
    check_eq("t6_pend9", 64'(dut.pending_q), 9);
    s_ack = 0; HRESET = 1'b1;
    cyc();
    s_ack = 1;
    #1 check_eq("t6_state", 64'(dut.state_q), 64'(IDLE));
    check_eq("t6_pend", 64'(dut.pending_q), 0);
    check_eq("t6_ack", 64'(m_ack), 0);
    check_eq("t6_stb", 64'(b_stb), 0);
    s_ack = 0; stb = 2'b00; HRESET = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
